top_cpu_serial: RTL and testbench

Bit-serial, microcoded 8-bit CPU core (`top_cpu`) for a pin-limited tile. It streams instruction and micro-instruction addresses out one bit per clock and receives instruction and micro-instruction words one bit per clock. Each macro-instruction is executed by a micro-program held in an external micro-ROM. The block contains the sequencer FSM, the decode registers, an 8×8-bit register file and the ALU.

---
 rtl/top_cpu_serial.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_top_cpu_serial.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_cpu_serial.sv
// ---------------------------------------------------------------------------
// top_cpu_serial
// Bit-serial, microcoded 8-bit CPU core. Macro PC and micro-ROM addresses are
// streamed out MSB first; macro- and micro-instruction words are streamed in
// MSB first. Each macro-instruction runs a micro-program of up to 32 entries
// located at inst_type*32 in an external micro-ROM.
//
// Ports
//   sys_clk            in   sole clock, rising edge
//   sys_reset          in   asynchronous, active-high reset
//   instr_in           in   serial macro-instruction bit (FETCH_INST)
//   m_instr_in         in   serial micro-instruction bit (FETCH_MINST)
//   inst_addr_stream   out  serial PC bit (SEND_PC), 0 elsewhere
//   m_inst_addr_stream out  serial micro-ROM address bit (SEND_MPC), 0 elsewhere
// ---------------------------------------------------------------------------
module top_cpu_serial #(
  parameter int unsigned PC_WIDTH          = 8,
  parameter int unsigned INST_WIDTH        = 16,
  parameter int unsigned MINST_WIDTH       = 28,
  parameter int unsigned M_INST_ADDR_WIDTH = 9
) (
  input  logic sys_clk,
  input  logic sys_reset,
  input  logic instr_in,
  input  logic m_instr_in,
  output logic inst_addr_stream,
  output logic m_inst_addr_stream
);

  localparam int unsigned CNT_W    = $clog2(MINST_WIDTH);
  localparam int unsigned PC_IDX_W = $clog2(PC_WIDTH);
  localparam int unsigned MA_IDX_W = $clog2(M_INST_ADDR_WIDTH);
  localparam int unsigned MPC_W    = 6;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NREGS    = 8;

  localparam logic [CNT_W-1:0] PC_LAST    = CNT_W'(PC_WIDTH - 1);
  localparam logic [CNT_W-1:0] INST_LAST  = CNT_W'(INST_WIDTH - 1);
  localparam logic [CNT_W-1:0] MADDR_LAST = CNT_W'(M_INST_ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] MINST_LAST = CNT_W'(MINST_WIDTH - 1);
  localparam logic [MPC_W-1:0] MPC_DONE   = MPC_W'(32);

  localparam logic [1:0] MT_NOP = 2'b00;
  localparam logic [1:0] MT_END = 2'b11;

  typedef enum logic [2:0] {
    S_SEND_PC,
    S_FETCH_INST,
    S_DECODE_INST,
    S_SEND_MPC,
    S_FETCH_MINST,
    S_DECODE_MINST,
    S_EXECUTE1,
    S_EXECUTE2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [CNT_W-1:0]       r_bit_idx;
  logic                   w_bit_last;
  logic [PC_WIDTH-1:0]    r_pc;
  logic [MPC_W-1:0]       r_m_pc;
  logic [MPC_W-1:0]       w_m_pc_next;
  logic [INST_WIDTH-1:0]  r_instr_reg;
  logic [MINST_WIDTH-1:0] r_m_instr_reg;

  // macro decode registers
  logic [2:0]          r_inst_type;
  logic                r_is_imm_active;
  logic [2:0]          r_reg_dst;
  logic [2:0]          r_reg_src_1;
  logic [2:0]          r_reg_src_2;
  logic [DATA_W-1:0]   r_imm;
  logic [PC_WIDTH-1:0] r_branch_target;

  // micro decode registers
  logic [1:0]        r_minstr_type;
  logic [1:0]        r_m_src_sel;
  logic [1:0]        r_m_dst_sel;
  logic [DATA_W-1:0] r_m_imm;
  logic [4:0]        r_mbranch_target;
  logic              r_is_m_imm_active;
  logic              r_alu_en_a;
  logic              r_alu_en_b;
  logic [2:0]        r_alu_op;
  logic              r_reg_file_en;
  logic              r_reg_file_rw;
  logic              r_is_branch;
  logic              r_is_nop;

  // datapath
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_bus;
  logic              r_should_branch;

  logic [2:0]                   w_src_idx;
  logic [2:0]                   w_dst_idx;
  logic [DATA_W-1:0]            w_operand;
  logic [DATA_W-1:0]            w_alu_result;
  logic [M_INST_ADDR_WIDTH-1:0] w_m_inst_addr;
  logic                         w_load_m_pc_en;
  logic                         w_reg_we;
  logic                         w_micro_done;

  assign w_bit_last     = (r_bit_idx == '0);
  assign w_load_m_pc_en = (r_state == S_EXECUTE2);
  assign w_reg_we       = w_load_m_pc_en & r_reg_file_en & r_reg_file_rw & ~r_is_nop;
  assign w_m_inst_addr  = M_INST_ADDR_WIDTH'({r_inst_type, 5'b00000})
                        + M_INST_ADDR_WIDTH'(r_m_pc[4:0]);

  // Micro register selectors: 0=src_1, 1=src_2, 2=dst, 3=R7
  always_comb begin
    w_src_idx = 3'd7;
    w_dst_idx = 3'd7;
    case (r_m_src_sel)
      2'd0:    w_src_idx = r_reg_src_1;
      2'd1:    w_src_idx = r_reg_src_2;
      2'd2:    w_src_idx = r_reg_dst;
      default: w_src_idx = 3'd7;
    endcase
    case (r_m_dst_sel)
      2'd0:    w_dst_idx = r_reg_src_1;
      2'd1:    w_dst_idx = r_reg_src_2;
      2'd2:    w_dst_idx = r_reg_dst;
      default: w_dst_idx = 3'd7;
    endcase
  end

  // Operand priority: micro immediate, then macro immediate on selector 1, then register
  always_comb begin
    w_operand = r_regs[w_src_idx];
    if (r_is_m_imm_active) begin
      w_operand = r_m_imm;
    end else if ((r_m_src_sel == 2'd1) && r_is_imm_active) begin
      w_operand = r_imm;
    end
  end

  // ALU, 8-bit wrapping
  always_comb begin
    w_alu_result = r_bus;
    case (r_alu_op)
      3'b000:  w_alu_result = r_bus;
      3'b001:  w_alu_result = r_a + r_b;
      3'b010:  w_alu_result = r_a - r_b;
      3'b011:  w_alu_result = r_a & r_b;
      3'b100:  w_alu_result = r_a | r_b;
      3'b101:  w_alu_result = r_a ^ r_b;
      3'b110:  w_alu_result = {r_a[DATA_W-2:0], 1'b0};
      default: w_alu_result = {1'b0, r_a[DATA_W-1:1]};
    endcase
  end

  // Micro PC successor; bit 5 set means the micro-program is finished
  always_comb begin
    w_m_pc_next = r_m_pc + MPC_W'(1);
    if (r_should_branch) begin
      w_m_pc_next = MPC_W'(r_mbranch_target);
    end else if (r_minstr_type == MT_END) begin
      w_m_pc_next = MPC_DONE;
    end
    w_micro_done = w_m_pc_next[MPC_W-1];
  end

  // Serial address outputs, decoded straight from registered state
  always_comb begin
    inst_addr_stream   = 1'b0;
    m_inst_addr_stream = 1'b0;
    if (r_state == S_SEND_PC) begin
      inst_addr_stream = r_pc[r_bit_idx[PC_IDX_W-1:0]];
    end
    if (r_state == S_SEND_MPC) begin
      m_inst_addr_stream = w_m_inst_addr[r_bit_idx[MA_IDX_W-1:0]];
    end
  end

  // State register
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_state <= S_SEND_PC;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_SEND_PC:      if (w_bit_last) w_next_state = S_FETCH_INST;
      S_FETCH_INST:   if (w_bit_last) w_next_state = S_DECODE_INST;
      S_DECODE_INST:  w_next_state = S_SEND_MPC;
      S_SEND_MPC:     if (w_bit_last) w_next_state = S_FETCH_MINST;
      S_FETCH_MINST:  if (w_bit_last) w_next_state = S_DECODE_MINST;
      S_DECODE_MINST: w_next_state = S_EXECUTE1;
      S_EXECUTE1:     if (w_bit_last) w_next_state = S_EXECUTE2;
      S_EXECUTE2:     w_next_state = w_micro_done ? S_SEND_PC : S_SEND_MPC;
      default:        w_next_state = S_SEND_PC;
    endcase
  end

  // Datapath, shift registers, decode registers and bit counter
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_bit_idx         <= PC_LAST;
      r_pc              <= '0;
      r_m_pc            <= '0;
      r_instr_reg       <= '0;
      r_m_instr_reg     <= '0;
      r_inst_type       <= '0;
      r_is_imm_active   <= 1'b0;
      r_reg_dst         <= '0;
      r_reg_src_1       <= '0;
      r_reg_src_2       <= '0;
      r_imm             <= '0;
      r_branch_target   <= '0;
      r_minstr_type     <= '0;
      r_m_src_sel       <= '0;
      r_m_dst_sel       <= '0;
      r_m_imm           <= '0;
      r_mbranch_target  <= '0;
      r_is_m_imm_active <= 1'b0;
      r_alu_en_a        <= 1'b0;
      r_alu_en_b        <= 1'b0;
      r_alu_op          <= '0;
      r_reg_file_en     <= 1'b0;
      r_reg_file_rw     <= 1'b0;
      r_is_branch       <= 1'b0;
      r_is_nop          <= 1'b0;
      r_a               <= '0;
      r_b               <= '0;
      r_bus             <= '0;
      r_should_branch   <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        S_SEND_PC: begin
          r_bit_idx <= w_bit_last ? INST_LAST : r_bit_idx - CNT_W'(1);
        end
        S_FETCH_INST: begin
          r_instr_reg <= {r_instr_reg[INST_WIDTH-2:0], instr_in};
          if (!w_bit_last) r_bit_idx <= r_bit_idx - CNT_W'(1);
        end
        S_DECODE_INST: begin
          r_inst_type     <= r_instr_reg[15:13];
          r_is_imm_active <= r_instr_reg[12];
          r_reg_dst       <= r_instr_reg[11:9];
          r_reg_src_1     <= r_instr_reg[8:6];
          r_reg_src_2     <= r_instr_reg[5:3];
          r_imm           <= r_instr_reg[7:0];
          r_branch_target <= r_instr_reg[PC_WIDTH-1:0];
          r_m_pc          <= '0;
          r_bit_idx       <= MADDR_LAST;
        end
        S_SEND_MPC: begin
          r_bit_idx <= w_bit_last ? MINST_LAST : r_bit_idx - CNT_W'(1);
        end
        S_FETCH_MINST: begin
          r_m_instr_reg <= {r_m_instr_reg[MINST_WIDTH-2:0], m_instr_in};
          if (!w_bit_last) r_bit_idx <= r_bit_idx - CNT_W'(1);
        end
        S_DECODE_MINST: begin
          r_minstr_type     <= r_m_instr_reg[27:26];
          r_m_src_sel       <= r_m_instr_reg[25:24];
          r_m_dst_sel       <= r_m_instr_reg[23:22];
          r_m_imm           <= r_m_instr_reg[21:14];
          r_mbranch_target  <= r_m_instr_reg[13:9];
          r_is_m_imm_active <= r_m_instr_reg[8];
          r_alu_en_a        <= r_m_instr_reg[7];
          r_alu_en_b        <= r_m_instr_reg[6];
          r_alu_op          <= r_m_instr_reg[5:3];
          r_reg_file_en     <= r_m_instr_reg[2];
          r_reg_file_rw     <= r_m_instr_reg[1];
          r_is_branch       <= r_m_instr_reg[0];
          r_is_nop          <= (r_m_instr_reg[27:26] == MT_NOP);
          r_bit_idx         <= CNT_W'(1);
        end
        S_EXECUTE1: begin
          // Two cycles: register-file read onto the bus, then latch A/B and compare
          if (!w_bit_last) begin
            r_bus     <= w_operand;
            r_bit_idx <= r_bit_idx - CNT_W'(1);
          end else begin
            if (!r_is_nop && r_alu_en_a) r_a <= r_bus;
            if (!r_is_nop && r_alu_en_b) r_b <= r_bus;
            r_should_branch <= r_is_branch & ~r_is_nop & (r_regs[w_dst_idx] == r_bus);
          end
        end
        S_EXECUTE2: begin
          if (w_reg_we) r_regs[w_dst_idx] <= w_alu_result;
          if (w_load_m_pc_en) r_m_pc <= w_m_pc_next;
          if (w_micro_done) begin
            r_pc      <= ((r_minstr_type == MT_END) && r_should_branch)
                         ? r_branch_target : r_pc + PC_WIDTH'(1);
            r_bit_idx <= PC_LAST;
          end else begin
            r_bit_idx <= MADDR_LAST;
          end
        end
        default: begin
          r_bit_idx <= PC_LAST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top_cpu_serial.sv
// ---------------------------------------------------------------------------
// tb_top_cpu_serial
// Acts as macro memory and micro-ROM for top_cpu_serial, follows the serial
// protocol cycle by cycle and compares streamed addresses and the register
// file against an instruction-level reference model.
// ---------------------------------------------------------------------------
module tb_top_cpu_serial;

  logic sys_clk = 1'b0;
  logic sys_reset;
  logic instr_in;
  logic m_instr_in;
  logic inst_addr_stream;
  logic m_inst_addr_stream;

  always #5 sys_clk = ~sys_clk;

  top_cpu_serial dut (
    .sys_clk            (sys_clk),
    .sys_reset          (sys_reset),
    .instr_in           (instr_in),
    .m_instr_in         (m_instr_in),
    .inst_addr_stream   (inst_addr_stream),
    .m_inst_addr_stream (m_inst_addr_stream)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [27:0] urom [512];

  // reference model state
  logic [7:0] mdl_pc;
  logic [7:0] mdl_regs [8];
  logic [7:0] mdl_a;
  logic [7:0] mdl_b;

  typedef struct {
    logic [15:0] inst;
    logic [7:0]  pc;
    logic [2:0]  rd;
    logic [7:0]  val;
  } vec_t;

  vec_t tbl [8];
  logic [7:0] got_pc_v;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [27:0] mk(input int ty, input int src, input int dst, input int imm,
                                     input int bt, input int ia, input int ea, input int eb,
                                     input int op, input int en, input int rw, input int br);
    return {2'(ty), 2'(src), 2'(dst), 8'(imm), 5'(bt), 1'(ia), 1'(ea), 1'(eb),
            3'(op), 1'(en), 1'(rw), 1'(br)};
  endfunction

  function automatic logic [2:0] pick(input logic [1:0] s, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    case (s)
      2'd0:    return rs1;
      2'd1:    return rs2;
      2'd2:    return rd;
      default: return 3'd7;
    endcase
  endfunction

  task automatic model_reset();
    mdl_pc = '0;
    mdl_a  = '0;
    mdl_b  = '0;
    for (int i = 0; i < 8; i++) mdl_regs[i] = '0;
  endtask

  task automatic capture_pc(output logic [7:0] v);
    v = '0;
    for (int i = 0; i < 8; i++) begin
      v = {v[6:0], inst_addr_stream};
      @(negedge sys_clk);
    end
  endtask

  task automatic capture_ma(output logic [8:0] v);
    v = '0;
    for (int i = 0; i < 9; i++) begin
      v = {v[7:0], m_inst_addr_stream};
      @(negedge sys_clk);
    end
  endtask

  task automatic drive_inst(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      instr_in = w[i];
      @(negedge sys_clk);
    end
    instr_in = 1'b0;
  endtask

  task automatic drive_minst(input logic [27:0] w, input int nbits);
    for (int i = 27; i > 27 - nbits; i--) begin
      m_instr_in = w[i];
      @(negedge sys_clk);
    end
    m_instr_in = 1'b0;
  endtask

  // One macro-instruction: stream/fetch/decode, then each micro-op until m_pc reaches 32
  task automatic run_macro(input logic [15:0] inst, output logic [7:0] got_pc);
    logic [2:0] ty, rd, rs1, rs2;
    logic       ia;
    logic [7:0] imm, opnd, res;
    logic [5:0] mpc;
    logic [8:0] got_ma, exp_ma;
    logic [27:0] mi;
    logic [1:0] mty, msrc, mdst;
    logic       sb;
    int         steps;
    capture_pc(got_pc);
    check("pc_stream", 32'(got_pc), 32'(mdl_pc));
    drive_inst(inst);
    @(negedge sys_clk);
    ty = inst[15:13]; ia = inst[12]; rd = inst[11:9];
    rs1 = inst[8:6]; rs2 = inst[5:3]; imm = inst[7:0];
    mpc = '0;
    steps = 0;
    while (mpc < 6'd32 && steps < 64) begin
      exp_ma = 9'(int'(ty) * 32 + int'(mpc));
      capture_ma(got_ma);
      check("maddr_stream", 32'(got_ma), 32'(exp_ma));
      mi = urom[exp_ma];
      drive_minst(mi, 28);
      repeat (4) @(negedge sys_clk);
      mty = mi[27:26]; msrc = mi[25:24]; mdst = mi[23:22];
      if (mi[8]) opnd = mi[21:14];
      else if (msrc == 2'd1 && ia) opnd = imm;
      else opnd = mdl_regs[pick(msrc, rd, rs1, rs2)];
      sb = 1'b0;
      if (mty != 2'b00) begin
        if (mi[7]) mdl_a = opnd;
        if (mi[6]) mdl_b = opnd;
        sb = mi[0] && (mdl_regs[pick(mdst, rd, rs1, rs2)] == opnd);
        case (mi[5:3])
          3'd0:    res = opnd;
          3'd1:    res = 8'(mdl_a + mdl_b);
          3'd2:    res = 8'(mdl_a - mdl_b);
          3'd3:    res = mdl_a & mdl_b;
          3'd4:    res = mdl_a | mdl_b;
          3'd5:    res = mdl_a ^ mdl_b;
          3'd6:    res = 8'(mdl_a * 2);
          default: res = mdl_a / 8'd2;
        endcase
        if (mi[2] && mi[1]) mdl_regs[pick(mdst, rd, rs1, rs2)] = res;
      end
      if (sb) mpc = 6'(mi[13:9]);
      else if (mty == 2'b11) mpc = 6'd32;
      else mpc = 6'(mpc + 1);
      if (mpc >= 6'd32) mdl_pc = (mty == 2'b11 && sb) ? inst[7:0] : 8'(mdl_pc + 1);
      steps++;
    end
    if (mpc < 6'd32) begin
      n_checks++;
      n_errors++;
      $display("FAIL micro_budget: got %0d micro-ops without finishing, required fewer than 64", steps);
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("reg_r%0d", i), 32'(dut.r_regs[i]), 32'(mdl_regs[i]));
    end
  endtask

  task automatic load_directed_rom();
    for (int i = 0; i < 512; i++) urom[i] = '0;
    // type 0: MOV rd <- src_2/imm
    urom[0]   = mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    urom[1]   = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // types 1..3: rd <- rs1 op (rs2|imm) with op ADD, SUB, XOR
    for (int t = 1; t <= 3; t++) begin
      urom[t*32+0] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      urom[t*32+1] = mk(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      urom[t*32+2] = mk(1, 0, 2, 0, 0, 0, 0, 0, (t == 1) ? 1 : (t == 2) ? 2 : 5, 1, 1, 0);
      urom[t*32+3] = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    // type 4: if rd == (rs2|imm) then rd <- 0x22 else rd <- 0x11
    urom[128] = mk(2, 1, 2, 0, 5, 0, 0, 0, 0, 0, 0, 1);
    urom[129] = mk(1, 0, 2, 8'h11, 0, 1, 0, 0, 0, 1, 1, 0);
    urom[130] = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    urom[133] = mk(1, 0, 2, 8'h22, 0, 1, 0, 0, 0, 1, 1, 0);
    urom[134] = mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Short random micro-programs with forward-only branches so each one ends
  task automatic load_random_rom();
    int len, a, ty, src, dst;
    for (int t = 0; t < 5; t++) begin
      len = $urandom_range(6, 2);
      for (int k = 0; k < 32; k++) begin
        a = t * 32 + k;
        if (k < len) begin
          ty  = $urandom_range(2, 0);
          dst = $urandom_range(3, 0);
          src = (ty == 2 && $urandom_range(1, 0) == 1) ? dst : $urandom_range(3, 0);
          urom[a] = mk(ty, src, dst, $urandom_range(255, 0), $urandom_range(len, k + 1),
                       (ty == 2) ? 0 : $urandom_range(1, 0), $urandom_range(1, 0),
                       $urandom_range(1, 0), $urandom_range(7, 0), $urandom_range(1, 0),
                       $urandom_range(1, 0), (ty == 2) ? 1 : $urandom_range(1, 0));
        end else if (k == len) begin
          urom[a] = mk(3, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(255, 0),
                       31, $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0),
                       $urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(1, 0),
                       $urandom_range(1, 0));
        end else begin
          urom[a] = {2'b00, 26'($urandom)};
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] ma;
    logic [15:0] rinst;

    tbl[0] = '{16'h1A40, 8'd0, 3'd5, 8'h40};  // MOV R5, #0x40
    tbl[1] = '{16'h1225, 8'd1, 3'd1, 8'h25};  // MOV R1, #0x25
    tbl[2] = '{16'h3450, 8'd2, 3'd2, 8'h75};  // ADD R2, R1, #0x50
    tbl[3] = '{16'h46A8, 8'd3, 3'd3, 8'h35};  // SUB R3, R2, R5
    tbl[4] = '{16'h4950, 8'd4, 3'd4, 8'hCB};  // SUB R4, R5, R2 (wraps)
    tbl[5] = '{16'h6CC8, 8'd5, 3'd6, 8'h10};  // XOR R6, R3, R1
    tbl[6] = '{16'h9A40, 8'd6, 3'd5, 8'h22};  // branch taken: R5 == 0x40
    tbl[7] = '{16'h9240, 8'd7, 3'd1, 8'h11};  // branch not taken: R1 != 0x40

    sys_reset  = 1'b1;
    instr_in   = 1'b0;
    m_instr_in = 1'b0;
    model_reset();
    load_directed_rom();
    repeat (3) @(negedge sys_clk);
    check("rst_inst_addr_stream", 32'(inst_addr_stream), 32'd0);
    check("rst_m_inst_addr_stream", 32'(m_inst_addr_stream), 32'd0);
    check("rst_pc", 32'(dut.r_pc), 32'd0);
    sys_reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_macro(tbl[i].inst, got_pc_v);
      check($sformatf("tbl%0d_pc", i), 32'(got_pc_v), 32'(tbl[i].pc));
      check($sformatf("tbl%0d_reg", i), 32'(dut.r_regs[tbl[i].rd]), 32'(tbl[i].val));
    end

    // Reset in the middle of a micro-instruction fetch
    capture_pc(got_pc_v);
    check("pre_abort_pc", 32'(got_pc_v), 32'd8);
    drive_inst(16'h6CC8);
    @(negedge sys_clk);
    capture_ma(ma);
    check("type3_mpc0_addr", 32'(ma), 32'h060);
    drive_minst(urom[96], 10);
    sys_reset = 1'b1;
    #1;
    check("abort_pc", 32'(dut.r_pc), 32'd0);
    check("abort_m_pc", 32'(dut.r_m_pc), 32'd0);
    check("abort_instr_reg", 32'(dut.r_instr_reg), 32'd0);
    check("abort_m_instr_reg", 32'(dut.r_m_instr_reg), 32'd0);
    check("abort_inst_addr_stream", 32'(inst_addr_stream), 32'd0);
    check("abort_m_inst_addr_stream", 32'(m_inst_addr_stream), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("abort_r%0d", i), 32'(dut.r_regs[i]), 32'd0);
    end
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_reset = 1'b0;
    model_reset();
    run_macro(16'h1225, got_pc_v);
    check("restart_pc", 32'(got_pc_v), 32'd0);
    check("restart_r1", 32'(dut.r_regs[1]), 32'h25);

    // Randomized programs against the reference model
    load_random_rom();
    for (int n = 0; n < 25; n++) begin
      rinst = {3'($urandom_range(4, 0)), 13'($urandom)};
      run_macro(rinst, got_pc_v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
